// File: rtl/add_err_monitor.sv
// Error-characterisation stage for an approximate adder: recomputes the exact
// sum of each accepted sample and accumulates SAE, WCE and error count over 2^LOG2_N samples.
module add_err_monitor #(
    parameter int W      = 16,
    parameter int LOG2_N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [W:0]        in_o,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W+LOG2_N:0] res_sae,
    output logic [W:0]        res_wce,
    output logic [LOG2_N:0]   res_errcnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LOG2_N:0] N_SAMPLES = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [LOG2_N:0] CNT_ONE   = {{LOG2_N{1'b0}}, 1'b1};

    // Absolute difference of two (W+1)-bit unsigned values.
    function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
        logic [W:0] d;
        if (x > y) begin
            d = x - y;
        end else begin
            d = y - x;
        end
        return d;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LOG2_N:0]   r_cnt;
    logic              r_s1_valid;
    logic [W:0]        r_s1_err;
    logic [W+LOG2_N:0] r_sae;
    logic [W:0]        r_wce;
    logic [LOG2_N:0]   r_errcnt;

    logic              w_clear;
    logic              w_cnt_full;
    logic              w_xfer;
    logic [W:0]        w_exact;
    logic [W:0]        w_err;

    assign w_clear    = (r_state == ST_IDLE) && start;
    assign w_cnt_full = (r_cnt == N_SAMPLES);
    assign in_ready   = (r_state == ST_RUN) && !w_cnt_full;
    assign w_xfer     = in_valid && in_ready;
    assign w_exact    = {1'b0, in_a} + {1'b0, in_b};
    assign w_err      = abs_diff(w_exact, in_o);

    assign busy       = (r_state != ST_IDLE);
    assign res_valid  = (r_state == ST_DONE);
    assign res_sae    = r_sae;
    assign res_wce    = r_wce;
    assign res_errcnt = r_errcnt;

    // Window control: next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_cnt_full) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Window control: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepted-sample counter and stage-1 error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= '0;
        end else if (w_clear) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= '0;
        end else begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_cnt    <= r_cnt + CNT_ONE;
                r_s1_err <= w_err;
            end
        end
    end

    // Stage-2 accumulators; results stay put after the window until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sae    <= '0;
            r_wce    <= '0;
            r_errcnt <= '0;
        end else if (w_clear) begin
            r_sae    <= '0;
            r_wce    <= '0;
            r_errcnt <= '0;
        end else if (r_s1_valid) begin
            r_sae <= r_sae + {{LOG2_N{1'b0}}, r_s1_err};
            if (r_s1_err > r_wce) begin
                r_wce <= r_s1_err;
            end
            if (r_s1_err != '0) begin
                r_errcnt <= r_errcnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_add_err_monitor.sv
// Self-checking bench for add_err_monitor (LOG2_N=2): a window-level reference model
// plus directed scenarios and randomized windows.
module tb_add_err_monitor;

    localparam int W  = 16;
    localparam int L  = 2;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic [W:0]      in_o = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [W+L:0]    res_sae;
    logic [W:0]      res_wce;
    logic [L:0]      res_errcnt;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    add_err_monitor #(.W(W), .LOG2_N(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sae(res_sae), .res_wce(res_wce), .res_errcnt(res_errcnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window phase (0 idle, 1 collecting, 2 draining, 3 results),
    // samples taken so far, and exact running sums of the window's errors.
    int     m_ph = 0;
    int     m_cnt = 0;
    longint m_sae = 0;
    longint m_wce = 0;
    longint m_ec = 0;
    bit     m_xfer = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_cnt = 0; m_sae = 0; m_wce = 0; m_ec = 0; m_xfer = 1'b0;
        end else begin
            longint ex, e;
            m_xfer = 1'b0;
            case (m_ph)
                0: if (start) begin
                    m_ph = 1; m_cnt = 0; m_sae = 0; m_wce = 0; m_ec = 0;
                end
                1: if (m_cnt == NS) begin
                    m_ph = 2;
                end else if (in_valid) begin
                    m_xfer = 1'b1;
                    m_cnt++;
                    ex = longint'(in_a) + longint'(in_b);
                    e  = (ex > longint'(in_o)) ? ex - longint'(in_o) : longint'(in_o) - ex;
                    m_sae += e;
                    if (e > m_wce) m_wce = e;
                    if (e != 0) m_ec++;
                end
                2: m_ph = 3;
                3: if (res_ready) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    // Compare DUT outputs with the model every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("in_ready", in_ready, (m_ph == 1 && m_cnt < NS));
        chk("busy", busy, (m_ph != 0));
        chk("res_valid", res_valid, (m_ph == 3));
        if (m_ph == 0 || m_ph == 3) begin
            chk("res_sae", res_sae, m_sae);
            chk("res_wce", res_wce, m_wce);
            chk("res_errcnt", res_errcnt, m_ec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W:0] o, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) begin
            in_a = W'($urandom); in_b = W'($urandom); in_o = (W+1)'($urandom);
            start = ($urandom_range(0, 7) == 0);
            tick();
        end
        start = 1'b0;
        in_a = a; in_b = b; in_o = o; in_valid = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!m_xfer && guard < 50);
        if (!m_xfer) begin
            n_errors++;
            $display("FAIL xfer_timeout: no transfer within %0d cycles", guard);
        end
        in_valid = 1'b0;
    endtask

    // Keep junk on the inputs until results appear, hold them, then acknowledge.
    task automatic finish_window(input int hold, input bit poke_start);
        int guard = 0;
        while (res_valid !== 1'b1 && guard < 20) begin
            in_valid = $urandom_range(0, 1);
            in_a = W'($urandom); in_b = W'($urandom); in_o = (W+1)'($urandom);
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("done_reached", res_valid, 1);
        for (int i = 0; i < hold; i++) begin
            start = poke_start && (i == hold / 2);
            tick();
        end
        start = poke_start;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        chk("idle_after_ack_busy", busy, 0);
        chk("idle_after_ack_valid", res_valid, 0);
    endtask

    task automatic check_res(input string tag, input longint sae, input longint wce, input longint ec);
        chk({tag, "_sae"}, res_sae, sae);
        chk({tag, "_wce"}, res_wce, wce);
        chk({tag, "_errcnt"}, res_errcnt, ec);
    endtask

    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W:0]   to [4];

    initial begin
        ta = '{16'd1, 16'hFFFF, 16'd5, 16'd0};
        tb = '{16'd2, 16'd1, 16'd5, 16'd0};
        to = '{17'd3, 17'd0, 17'd12, 17'd0};

        repeat (3) tick();
        chk("reset_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        check_res("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // All-exact window.
        do_start();
        feed_one(16'd1, 16'd2, 17'd3, 0);
        feed_one(16'hFFFF, 16'd1, 17'h10000, 0);
        feed_one(16'd7, 16'd8, 17'd15, 0);
        feed_one(16'd0, 16'd0, 17'd0, 0);
        finish_window(0, 1'b0);
        check_res("exact", 0, 0, 0);

        // Mixed errors 0, 0x10000, 2, 0 back to back.
        do_start();
        for (int i = 0; i < 4; i++) feed_one(ta[i], tb[i], to[i], 0);
        finish_window(1, 1'b0);
        check_res("mixed", 64'h10002, 64'h10000, 2);

        // Same samples with 3-cycle gaps; long hold with an ignored start.
        do_start();
        for (int i = 0; i < 4; i++) feed_one(ta[i], tb[i], to[i], 3);
        chk("ready_fall", in_ready, 0);
        finish_window(10, 1'b1);
        check_res("gapped", 64'h10002, 64'h10000, 2);
        chk("start_ignored_busy", busy, 0);

        // Reset mid-window.
        do_start();
        feed_one(16'd9, 16'd9, 17'd0, 0);
        feed_one(16'd3, 16'd4, 17'd1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_valid", res_valid, 0);
        check_res("midrst", 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        for (int i = 0; i < 4; i++) feed_one(16'(i * 100), 16'(i + 7), 17'(i * 100 + i + 7), 1);
        finish_window(2, 1'b0);
        check_res("post_rst", 0, 0, 0);

        // Worst-case error on every sample.
        do_start();
        for (int i = 0; i < 4; i++) feed_one(16'hFFFF, 16'hFFFF, 17'd0, 0);
        finish_window(0, 1'b0);
        check_res("maxerr", 64'h7FFF8, 64'h1FFFE, 4);

        // Randomized windows.
        for (int w = 0; w < 30; w++) begin
            if ($urandom_range(0, 1) == 1) tick();
            do_start();
            for (int i = 0; i < NS; i++) begin
                logic [W-1:0] a, b;
                logic [W:0]   o, ex;
                int mode;
                a = W'($urandom); b = W'($urandom);
                ex = {1'b0, a} + {1'b0, b};
                mode = $urandom_range(0, 3);
                if (mode == 0) o = ex;
                else if (mode == 1) o = ex + (W+1)'($urandom_range(1, 5));
                else if (mode == 2) o = ex - (W+1)'($urandom_range(1, 300));
                else o = (W+1)'($urandom);
                feed_one(a, b, o, $urandom_range(0, 2));
            end
            finish_window($urandom_range(0, 3), $urandom_range(0, 1));
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
